// File: rtl/ntt_pkg.sv
// Shared NTT definitions: butterfly mode encoding, default widths and the
// modular add/subtract/halve helpers used by the butterfly and the NTT controller.
// The helpers work on NTT_MAX_W-bit operands so any W <= NTT_MAX_W-1 can
// zero-extend into them and truncate the result back.
package ntt_pkg;

  localparam logic BF_MODE_CT = 1'b0;  // Cooley-Tukey:    (a+wb, a-wb)
  localparam logic BF_MODE_GS = 1'b1;  // Gentleman-Sande: (a+b, (a-b)w)

  localparam int NTT_W_DEF       = 16;
  localparam int NTT_MUL_LAT_DEF = 4;
  localparam int NTT_MAX_W       = 32;

  // Per-beat tag carried alongside the datapath.
  typedef struct packed {
    logic valid;
    logic mode;
    logic halve;
  } bf_tag_t;

  // (a + b) mod q for a, b < q: one extra bit of headroom, single conditional subtract.
  function automatic logic [NTT_MAX_W-1:0] mod_add(
    input logic [NTT_MAX_W-1:0] a,
    input logic [NTT_MAX_W-1:0] b,
    input logic [NTT_MAX_W-1:0] q
  );
    logic [NTT_MAX_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, q}) begin
      s = s - {1'b0, q};
    end
    return s[NTT_MAX_W-1:0];
  endfunction

  // (a - b) mod q for a, b < q: the top bit of the difference is the borrow.
  function automatic logic [NTT_MAX_W-1:0] mod_sub(
    input logic [NTT_MAX_W-1:0] a,
    input logic [NTT_MAX_W-1:0] b,
    input logic [NTT_MAX_W-1:0] q
  );
    logic [NTT_MAX_W:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[NTT_MAX_W]) begin
      d = d + {1'b0, q};
    end
    return d[NTT_MAX_W-1:0];
  endfunction

  // x * 2^-1 mod q for odd q: even x shifts, odd x becomes (x+q)/2 (x+q is even).
  function automatic logic [NTT_MAX_W-1:0] mod_half(
    input logic [NTT_MAX_W-1:0] x,
    input logic [NTT_MAX_W-1:0] q
  );
    logic [NTT_MAX_W:0] s;
    if (x[0]) begin
      s = {1'b0, x} + {1'b0, q};
    end else begin
      s = {1'b0, x};
    end
    return s[NTT_MAX_W:1];
  endfunction

endpackage

// File: rtl/mod_mult_pipe.sv
// Modular multiplier: p = (a*b) mod q, available MUL_LAT cycles after the
// operands are presented. No handshake; the caller tracks validity.
module mod_mult_pipe #(
  parameter int W       = 16,
  parameter int MUL_LAT = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] q,
  output logic [W-1:0] p
);

  logic [2*W-1:0] prod;
  logic [2*W-1:0] q_ext;
  logic [2*W-1:0] rem;
  logic [W-1:0]   pipe [MUL_LAT];

  // Full-width product and reduction; the register chain below retimes it.
  always_comb begin
    prod  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    q_ext = {{W{1'b0}}, q};
    rem   = prod % q_ext;
  end

  // MUL_LAT-deep result pipeline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MUL_LAT; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= W'(rem);
      for (int i = 1; i < MUL_LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign p = pipe[MUL_LAT-1];

endmodule

// File: rtl/ntt_butterfly_pipe.sv
// Fully pipelined NTT/INTT butterfly. Each beat picks CT or GS and optional
// 1/2 scaling. Stages: input register, S0 (GS pre-add/sub), MUL_LAT multiplier
// stages with a matching bypass, final add/sub/halve register.
//
// Handshake: in_valid=1 means in_* carry a beat this cycle and it is always
// accepted (no ready, no backpressure); out_valid=1 means out_even/out_odd
// carry a result for exactly this cycle. flush kills everything in flight.
module ntt_butterfly_pipe
  import ntt_pkg::*;
#(
  parameter int W       = NTT_W_DEF,
  parameter int MUL_LAT = NTT_MUL_LAT_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  input  logic         in_mode,
  input  logic         in_halve,
  input  logic [W-1:0] q,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [W-1:0] in_w,
  output logic         out_valid,
  output logic [W-1:0] out_even,
  output logic [W-1:0] out_odd,
  output logic         busy
);

  localparam int LAT      = MUL_LAT + 2;
  localparam int TAG_LAST = LAT - 1;

  // tag[0] input register, tag[1] S0, tag[2..LAT-1] multiplier stages.
  bf_tag_t      tag [LAT];

  logic [W-1:0] a_r, b_r, w_r;
  logic [W-1:0] s0_x, s0_y, s0_w;
  logic [W-1:0] s0_x_d, s0_y_d;
  logic [W-1:0] byp [MUL_LAT];
  logic [W-1:0] prod;
  logic [W-1:0] fin_even, fin_odd;

  function automatic logic [NTT_MAX_W-1:0] widen(input logic [W-1:0] x);
    return NTT_MAX_W'(x);
  endfunction

  function automatic logic [W-1:0] narrow(input logic [NTT_MAX_W-1:0] x);
    return W'(x);
  endfunction

  // Tag pipeline: valid/mode/halve shift with the beat; flush clears every valid bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) begin
        tag[i] <= '0;
      end
    end else begin
      tag[0].valid <= in_valid & ~flush;
      tag[0].mode  <= in_valid & in_mode;
      tag[0].halve <= in_valid & in_halve;
      for (int i = 1; i < LAT; i++) begin
        tag[i].valid <= tag[i-1].valid & ~flush;
        tag[i].mode  <= tag[i-1].mode;
        tag[i].halve <= tag[i-1].halve;
      end
    end
  end

  // Input register for the operands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_r <= '0;
      b_r <= '0;
      w_r <= '0;
    end else begin
      a_r <= in_a;
      b_r <= in_b;
      w_r <= in_w;
    end
  end

  // S0 operand selection: GS pre-computes sum/diff, CT passes a/b through.
  always_comb begin
    s0_x_d = a_r;
    s0_y_d = b_r;
    if (tag[0].mode == BF_MODE_GS) begin
      s0_x_d = narrow(mod_add(widen(a_r), widen(b_r), widen(q)));
      s0_y_d = narrow(mod_sub(widen(a_r), widen(b_r), widen(q)));
    end
  end

  // S0 register: x is the bypass operand, y*w goes to the multiplier.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s0_x <= '0;
      s0_y <= '0;
      s0_w <= '0;
    end else begin
      s0_x <= s0_x_d;
      s0_y <= s0_y_d;
      s0_w <= w_r;
    end
  end

  mod_mult_pipe #(
    .W       (W),
    .MUL_LAT (MUL_LAT)
  ) u_mult (
    .clk   (clk),
    .reset (reset),
    .a     (s0_y),
    .b     (s0_w),
    .q     (q),
    .p     (prod)
  );

  // Bypass shift register keeps a (CT) or sum (GS) aligned with the product.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MUL_LAT; i++) begin
        byp[i] <= '0;
      end
    end else begin
      byp[0] <= s0_x;
      for (int i = 1; i < MUL_LAT; i++) begin
        byp[i] <= byp[i-1];
      end
    end
  end

  // Final combine: CT butterfly or GS pass-through, then optional halving.
  always_comb begin
    if (tag[TAG_LAST].mode == BF_MODE_CT) begin
      fin_even = narrow(mod_add(widen(byp[MUL_LAT-1]), widen(prod), widen(q)));
      fin_odd  = narrow(mod_sub(widen(byp[MUL_LAT-1]), widen(prod), widen(q)));
    end else begin
      fin_even = byp[MUL_LAT-1];
      fin_odd  = prod;
    end
    if (tag[TAG_LAST].halve) begin
      fin_even = narrow(mod_half(widen(fin_even), widen(q)));
      fin_odd  = narrow(mod_half(widen(fin_odd), widen(q)));
    end
  end

  // Output register: data only moves for a live beat, otherwise it holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_even  <= '0;
      out_odd   <= '0;
    end else begin
      out_valid <= tag[TAG_LAST].valid & ~flush;
      if (tag[TAG_LAST].valid & ~flush) begin
        out_even <= fin_even;
        out_odd  <= fin_odd;
      end
    end
  end

  // busy: any beat anywhere in the pipeline, including the output register.
  always_comb begin
    busy = out_valid;
    for (int i = 0; i < LAT; i++) begin
      busy = busy | tag[i].valid;
    end
  end

endmodule

// File: tb/tb_ntt_butterfly_pipe.sv
// Bench for ntt_butterfly_pipe: directed beats with known answers, a random
// mixed-mode stream against an independent integer model, flush and async reset.
module tb_ntt_butterfly_pipe;
  import ntt_pkg::*;

  localparam int W       = 16;
  localparam int MUL_LAT = 4;
  localparam int LAT     = MUL_LAT + 2;
  localparam int EXP_W   = 32 + 2 * W;  // {due cycle, even, odd}

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic         in_valid;
  logic         in_mode;
  logic         in_halve;
  logic [W-1:0] q;
  logic [W-1:0] in_a, in_b, in_w;
  logic         out_valid;
  logic [W-1:0] out_even, out_odd;
  logic         busy;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  bit mon_en       = 1'b0;

  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] mon_front;
  logic             mon_exp_v;

  ntt_butterfly_pipe #(
    .W       (W),
    .MUL_LAT (MUL_LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_mode   (in_mode),
    .in_halve  (in_halve),
    .q         (q),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_w      (in_w),
    .out_valid (out_valid),
    .out_even  (out_even),
    .out_odd   (out_odd),
    .busy      (busy)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Independent reference: plain integer arithmetic, halving as multiply by (q+1)/2.
  function automatic logic [2*W-1:0] ref_bf(input logic mode, input logic halve,
                                            input longint qq, input longint a,
                                            input longint b, input longint w);
    longint e, o, p;
    if (mode == BF_MODE_CT) begin
      p = (b * w) % qq;
      e = (a + p) % qq;
      o = (a - p + qq) % qq;
    end else begin
      e = (a + b) % qq;
      o = (((a - b + qq) % qq) * w) % qq;
    end
    if (halve) begin
      e = (e * ((qq + 1) / 2)) % qq;
      o = (o * ((qq + 1) / 2)) % qq;
    end
    return {W'(e), W'(o)};
  endfunction

  // Scoreboard: every cycle out_valid must match whether a result is due now.
  always @(negedge clk) begin
    if (mon_en) begin
      while (exp_q.size() > 0 && exp_q[0][EXP_W-1 -: 32] < 32'(cyc)) begin
        check_eq("late_beat", 32'(cyc), exp_q[0][EXP_W-1 -: 32]);
        void'(exp_q.pop_front());
      end
      mon_exp_v = (exp_q.size() > 0) && (exp_q[0][EXP_W-1 -: 32] == 32'(cyc));
      check_eq("out_valid", 32'(out_valid), 32'(mon_exp_v));
      if (mon_exp_v) begin
        mon_front = exp_q.pop_front();
        check_eq("out_even", 32'(out_even), 32'(mon_front[2*W-1:W]));
        check_eq("out_odd", 32'(out_odd), 32'(mon_front[W-1:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_beat(input logic mode, input logic halve, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [W-1:0] w,
                            input logic [W-1:0] exp_e, input logic [W-1:0] exp_o);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_mode  = mode;
    in_halve = halve;
    in_a     = a;
    in_b     = b;
    in_w     = w;
    exp_q.push_back({32'(cyc + 1 + LAT), exp_e, exp_o});
  endtask

  task automatic drive_rand_beat();
    logic         m, h;
    logic [W-1:0] a, b, w;
    logic [2*W-1:0] r;
    m = 1'($urandom_range(0, 1));
    h = 1'($urandom_range(0, 1));
    a = W'($urandom_range(0, int'(q) - 1));
    b = W'($urandom_range(0, int'(q) - 1));
    w = W'($urandom_range(0, int'(q) - 1));
    r = ref_bf(m, h, longint'(q), longint'(a), longint'(b), longint'(w));
    drive_beat(m, h, a, b, w, r[2*W-1:W], r[W-1:0]);
  endtask

  // Idle cycle: mode/halve/data wiggle to show they are ignored without in_valid.
  task automatic idle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_mode  = 1'($urandom_range(0, 1));
    in_halve = 1'($urandom_range(0, 1));
    in_a     = W'($urandom_range(0, 65535));
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (exp_q.size() != 0 || busy); i++) begin
      @(posedge clk);
    end
    check_eq("drain_done", 32'(exp_q.size() == 0 && !busy), 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset    = 1'b1;
    flush    = 1'b0;
    in_valid = 1'b0;
    in_mode  = 1'b0;
    in_halve = 1'b0;
    in_a     = '0;
    in_b     = '0;
    in_w     = '0;
    q        = W'(17);

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_out_even", 32'(out_even), 32'd0);
    check_eq("rst_out_odd", 32'(out_odd), 32'd0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // CT basic, then output hold while idle
    drive_beat(BF_MODE_CT, 1'b0, 16'd5, 16'd3, 16'd2, 16'd11, 16'd16);
    idle();
    drain();
    repeat (3) idle();
    check_eq("hold_even", 32'(out_even), 32'd11);
    check_eq("hold_odd", 32'(out_odd), 32'd16);

    // GS with and without halving, back to back
    drive_beat(BF_MODE_GS, 1'b1, 16'd5, 16'd3, 16'd2, 16'd4, 16'd2);
    drive_beat(BF_MODE_GS, 1'b0, 16'd5, 16'd3, 16'd2, 16'd8, 16'd4);
    idle();
    drain();

    // wrap cases and halving an odd value
    drive_beat(BF_MODE_CT, 1'b0, 16'd16, 16'd16, 16'd1, 16'd15, 16'd0);
    drive_beat(BF_MODE_GS, 1'b1, 16'd11, 16'd0, 16'd1, 16'd14, 16'd14);
    idle();
    drain();

    // random mixed stream with gaps
    q = W'(3329);
    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) idle();
      end
      drive_rand_beat();
    end
    idle();
    drain();

    // flush with three beats in flight plus one on the flush edge
    q = W'(17);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_mode  = 1'($urandom_range(0, 1));
      in_halve = 1'($urandom_range(0, 1));
      in_a     = W'($urandom_range(0, 16));
      in_b     = W'($urandom_range(0, 16));
      in_w     = W'($urandom_range(0, 16));
    end
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(negedge clk);
    check_eq("busy_pre_flush", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("busy_post_flush", 32'(busy), 32'd0);
    repeat (LAT + 3) idle();
    drive_beat(BF_MODE_CT, 1'b0, 16'd5, 16'd3, 16'd2, 16'd11, 16'd16);
    idle();
    drain();

    // asynchronous reset mid-stream
    q = W'(7681);
    for (int i = 0; i < LAT + 3; i++) begin
      drive_rand_beat();
    end
    #2;
    mon_en = 1'b0;
    reset  = 1'b1;
    #1;
    check_eq("async_rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("async_rst_busy", 32'(busy), 32'd0);
    check_eq("async_rst_out_even", 32'(out_even), 32'd0);
    check_eq("async_rst_out_odd", 32'(out_odd), 32'd0);
    exp_q.delete();
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;
    drive_beat(BF_MODE_CT, 1'b0, 16'd1, 16'd1, 16'd1, 16'd2, 16'd0);
    idle();
    drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
